vga_timing_gen: RTL and testbench

Generates 640x480 @ 60 Hz VGA raster timing from the 25 MHz pixel clock. It produces the horizontal/vertical sync pulses, the active-video flag and the current pixel coordinates. It sits directly upstream of every sprite/renderer stage; those stages consume `DrawX`, `DrawY` and `blank` on the same `vga_clk`. Its `hs`/`vs` go straight to the VGA connector pins.

---
 rtl/vga_pkg.sv | 14 +
 rtl/vga_timing_gen_if.sv | 20 ++
 rtl/vga_wrap_counter.sv | 20 ++
 rtl/vga_timing_gen.sv | 74 +++++++
 tb/tb_vga_timing_gen.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared coordinate type and default 640x480@60 timing.
package vga_pkg;
    typedef logic [9:0] coord_t;
    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;
    localparam int DEF_H_TOTAL   = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int DEF_V_TOTAL   = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster outputs toward renderers and the connector.
// frame_count exists only when VGA_FRAME_COUNT_EN is defined.
interface vga_timing_gen_if;
    import vga_pkg::*;
    logic   hs;
    logic   vs;
    logic   blank;
    logic   line_end;
    logic   frame_end;
    coord_t DrawX;
    coord_t DrawY;
`ifdef VGA_FRAME_COUNT_EN
    logic [7:0] frame_count;
    modport master (output hs, vs, blank, line_end, frame_end, DrawX, DrawY, frame_count);
    modport slave  (input  hs, vs, blank, line_end, frame_end, DrawX, DrawY, frame_count);
`else
    modport master (output hs, vs, blank, line_end, frame_end, DrawX, DrawY);
    modport slave  (input  hs, vs, blank, line_end, frame_end, DrawX, DrawY);
`endif
endinterface

// File: rtl/vga_wrap_counter.sv
// vga_wrap_counter: modulo-N counter with enable; exposes next value and wrap flag.
module vga_wrap_counter
    import vga_pkg::*;
#(
    parameter int N = 2
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    output coord_t count,
    output coord_t next,
    output logic   wrap
);
    assign wrap = en && (count == coord_t'(N - 1));
    assign next = wrap ? '0 : count + coord_t'(en);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) count <= '0;
        else     count <= next;
    end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing; all outputs registered from next-state counters.
// Optional VGA_FRAME_COUNT_EN adds an 8-bit frame counter.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK
) (
    input  logic              vga_clk,
    input  logic              reset,
    vga_timing_gen_if.master  vga
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam coord_t HS_LO  = coord_t'(H_VISIBLE + H_FRONT);
    localparam coord_t HS_HI  = coord_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam coord_t VS_LO  = coord_t'(V_VISIBLE + V_FRONT);
    localparam coord_t VS_HI  = coord_t'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam coord_t H_VIS  = coord_t'(H_VISIBLE);
    localparam coord_t V_VIS  = coord_t'(V_VISIBLE);
    localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end

    coord_t dx, dy, hn, vn;
    logic   h_wrap, v_wrap;
    logic   unused_v_wrap;

    vga_wrap_counter #(.N(H_TOTAL)) u_h (
        .clk(vga_clk), .rst(reset), .en(1'b1),
        .count(dx), .next(hn), .wrap(h_wrap)
    );
    vga_wrap_counter #(.N(V_TOTAL)) u_v (
        .clk(vga_clk), .rst(reset), .en(h_wrap),
        .count(dy), .next(vn), .wrap(v_wrap)
    );

    assign vga.DrawX     = dx;
    assign vga.DrawY     = dy;
    assign unused_v_wrap = v_wrap;

    // Decoding next-state values keeps every flag aligned with DrawX/DrawY.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            vga.hs        <= 1'b1;
            vga.vs        <= 1'b1;
            vga.blank     <= 1'b1;
            vga.line_end  <= 1'b0;
            vga.frame_end <= 1'b0;
        end else begin
            vga.hs        <= !(hn >= HS_LO && hn <= HS_HI);
            vga.vs        <= !(vn >= VS_LO && vn <= VS_HI);
            vga.blank     <= (hn < H_VIS) && (vn < V_VIS);
            vga.line_end  <= hn == H_LAST;
            vga.frame_end <= (hn == H_LAST) && (vn == V_LAST);
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset)              vga.frame_count <= '0;
        else if (vga.frame_end) vga.frame_count <= vga.frame_count + 8'd1;
    end
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: default-timing instance for line checks, small-timing instance for frame checks.
module tb_vga_timing_gen;
    import vga_pkg::*;

    typedef struct {
        int n;
        int x;
        int y;
        bit hs;
        bit vs;
        bit bl;
        bit le;
        bit fe;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nchk = 0;
    int   nerr = 0;
    int   cyc  = 0;

    always #5 clk = ~clk;

    vga_timing_gen_if if_f();
    vga_timing_gen_if if_s();

    vga_timing_gen u_full (.vga_clk(clk), .reset(rst), .vga(if_f));

    // 15 x 12 raster: hs low at X 10..12, vs low at Y 8..9, visible 8 x 6.
    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)
    ) u_small (.vga_clk(clk), .reset(rst), .vga(if_s));

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cyc = 0;
    endtask

    vec_t tbl[12];

    initial begin
        int lo, bk, le, fall_x, rise_x, n;
        int vs_lo, fe_cnt, first_fe, viol, fe_bad;
        int bfr[3];
        logic prev_hs;

        tbl[0]  = '{0,    0,   0, 1, 1, 1, 0, 0};
        tbl[1]  = '{1,    1,   0, 1, 1, 1, 0, 0};
        tbl[2]  = '{639,  639, 0, 1, 1, 1, 0, 0};
        tbl[3]  = '{640,  640, 0, 1, 1, 0, 0, 0};
        tbl[4]  = '{655,  655, 0, 1, 1, 0, 0, 0};
        tbl[5]  = '{656,  656, 0, 0, 1, 0, 0, 0};
        tbl[6]  = '{751,  751, 0, 0, 1, 0, 0, 0};
        tbl[7]  = '{752,  752, 0, 1, 1, 0, 0, 0};
        tbl[8]  = '{799,  799, 0, 1, 1, 0, 1, 0};
        tbl[9]  = '{800,  0,   1, 1, 1, 1, 0, 0};
        tbl[10] = '{1599, 799, 1, 1, 1, 0, 1, 0};
        tbl[11] = '{1600, 0,   2, 1, 1, 1, 0, 0};

        do_reset();
        foreach (tbl[i]) begin
            while (cyc < tbl[i].n) step();
            chk($sformatf("vec%0d DrawX", tbl[i].n), 32'(if_f.DrawX), tbl[i].x);
            chk($sformatf("vec%0d DrawY", tbl[i].n), 32'(if_f.DrawY), tbl[i].y);
            chk($sformatf("vec%0d hs", tbl[i].n), 32'(if_f.hs), 32'(tbl[i].hs));
            chk($sformatf("vec%0d vs", tbl[i].n), 32'(if_f.vs), 32'(tbl[i].vs));
            chk($sformatf("vec%0d blank", tbl[i].n), 32'(if_f.blank), 32'(tbl[i].bl));
            chk($sformatf("vec%0d line_end", tbl[i].n), 32'(if_f.line_end), 32'(tbl[i].le));
            chk($sformatf("vec%0d frame_end", tbl[i].n), 32'(if_f.frame_end), 32'(tbl[i].fe));
        end

        // One full line (line 2) of the default raster.
        lo = 0; bk = 0; le = 0; fall_x = -1; rise_x = -1; prev_hs = 1'b1;
        for (int i = 0; i < 800; i++) begin
            if (!if_f.hs) lo++;
            if (prev_hs && !if_f.hs) fall_x = int'(if_f.DrawX);
            if (!prev_hs && if_f.hs) rise_x = int'(if_f.DrawX);
            if (!if_f.blank) bk++;
            if (if_f.line_end) le++;
            prev_hs = if_f.hs;
            step();
        end
        chk("line hs low cycles", lo, 96);
        chk("line hs fall x", fall_x, 656);
        chk("line hs rise x", rise_x, 752);
        chk("line blank low cycles", bk, 160);
        chk("line line_end pulses", le, 1);

        // Three frames of the small raster.
        do_reset();
        vs_lo = 0; fe_cnt = 0; first_fe = -1; viol = 0; fe_bad = 0;
        bfr = '{0, 0, 0};
        for (int i = 0; i < 540; i++) begin
            if (if_s.DrawX >= 10'd15 || if_s.DrawY >= 10'd12) viol++;
            if (!if_s.vs) vs_lo++;
            if (if_s.blank) bfr[i / 180]++;
            if (if_s.frame_end) begin
                fe_cnt++;
                if (first_fe < 0) first_fe = i;
                if (if_s.DrawX != 10'd14 || if_s.DrawY != 10'd11) fe_bad++;
            end
            step();
        end
        chk("frame vs low cycles", vs_lo, 90);
        chk("frame frame_end pulses", fe_cnt, 3);
        chk("frame first frame_end cycle", first_fe, 179);
        chk("frame frame_end position", fe_bad, 0);
        chk("frame bounds", viol, 0);
        foreach (bfr[f]) chk($sformatf("frame%0d blank count", f), bfr[f], 48);
        chk("wrap DrawX", 32'(if_s.DrawX), 0);
        chk("wrap DrawY", 32'(if_s.DrawY), 0);
        chk("wrap blank", 32'(if_s.blank), 1);

        // Asynchronous reset mid-frame.
        do_reset();
        repeat (65) step();
        chk("mid DrawX", 32'(if_s.DrawX), 5);
        chk("mid DrawY", 32'(if_s.DrawY), 4);
        #1 rst = 1'b1;
        #1;
        chk("async DrawX", 32'(if_s.DrawX), 0);
        chk("async DrawY", 32'(if_s.DrawY), 0);
        chk("async hs", 32'(if_s.hs), 1);
        chk("async vs", 32'(if_s.vs), 1);
        chk("async blank", 32'(if_s.blank), 1);
        chk("async line_end", 32'(if_s.line_end), 0);
        chk("async frame_end", 32'(if_s.frame_end), 0);
        chk("async full DrawX", 32'(if_f.DrawX), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        step();
        chk("rel DrawX", 32'(if_s.DrawX), 1);
        chk("rel DrawY", 32'(if_s.DrawY), 0);
        n = 1;
        while (!if_s.frame_end && n < 400) begin
            step();
            n++;
        end
        chk("rel first frame_end cycle", n, 179);

`ifdef VGA_FRAME_COUNT_EN
        do_reset();
        chk("fc reset", 32'(if_s.frame_count), 0);
        for (int k = 0; k < 257; k++) begin
            n = 0;
            while (!if_s.frame_end && n < 200) begin
                step();
                n++;
            end
            chk($sformatf("fc frame_end seen %0d", k), 32'(if_s.frame_end), 1);
            chk($sformatf("fc at end %0d", k), 32'(if_s.frame_count), k % 256);
            step();
            chk($sformatf("fc after end %0d", k), 32'(if_s.frame_count), (k + 1) % 256);
        end
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
